// File: rtl/stk_cmd_issuer.sv
// Command issuer for one stk engine port: queues client requests, drives them
// onto the stk command interface until acked, and returns POP responses in order.
package cfg_pkg;
  localparam int ENGS_N = 4;
endpackage

package stk_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_RSV  = 2'd3
  } opcode_t;
endpackage

module stk_cmd_issuer
  import stk_pkg::*;
#(
  parameter int ENG_ID = 0,
  parameter int REQ_N  = 4,
  parameter int RSP_N  = 4,
  parameter int DAT_W  = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req_vld,
  input  opcode_t                    i_req_opcode,
  input  logic [DAT_W-1:0]           i_req_dat,
  output logic                       o_req_rdy,
  output opcode_t                    o_cmd_opcode,
  output logic [DAT_W-1:0]           o_cmd_dat,
  input  logic                       i_cmd_ack,
  input  logic [cfg_pkg::ENGS_N-1:0] i_rsp_vld,
  input  logic [DAT_W-1:0]           i_rsp_dat,
  output logic                       o_rsp_vld,
  output logic [DAT_W-1:0]           o_rsp_dat,
  input  logic                       i_rsp_rdy,
  output logic                       o_busy,
  output logic                       o_err
);
  localparam int QAW = $clog2(REQ_N);
  localparam int RAW = $clog2(RSP_N);

  typedef struct packed {
    opcode_t          op;
    logic [DAT_W-1:0] dat;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, STALL} state_t;

  req_t             req_mem_q [REQ_N];
  logic [QAW-1:0]   qwr_q, qrd_q;
  logic [QAW:0]     qcnt_q, qcnt_d;
  logic             rdy_q;

  logic [DAT_W-1:0] rbuf_q [RSP_N];
  logic [RAW-1:0]   rwr_q, rrd_q;
  logic [RAW:0]     rcnt_q, rcnt_d;
  logic [RAW:0]     out_q, out_d;
  logic [RAW+1:0]   credit_sum;

  state_t           state_q, state_d;
  opcode_t          cmd_op_q, cmd_op_d;
  logic [DAT_W-1:0] cmd_dat_q, cmd_dat_d;
  logic             err_q, err_d;

  logic             req_acc, op_ok, enq, ack_fire, pop_ack;
  logic             rsp_hit, rsp_wr, rsp_bad, rsp_rd, credit;
  logic [QAW-1:0]   nh_idx;
  logic             nh_avail;
  req_t             nh;
  logic             unused_rsp_vld;

  assign unused_rsp_vld = ^i_rsp_vld;

  always_comb begin
    req_acc  = i_req_vld & rdy_q;
    op_ok    = (i_req_opcode == OP_PUSH) || (i_req_opcode == OP_POP);
    enq      = req_acc & op_ok;
    ack_fire = (state_q == DRIVE) & i_cmd_ack;
    pop_ack  = ack_fire & (cmd_op_q == OP_POP);
    rsp_hit  = i_rsp_vld[ENG_ID];
    rsp_wr   = rsp_hit & (out_q != '0);
    rsp_bad  = rsp_hit & (out_q == '0);
    rsp_rd   = (rcnt_q != '0) & i_rsp_rdy;

    qcnt_d = qcnt_q + (QAW+1)'(enq) - (QAW+1)'(ack_fire);
    out_d  = out_q + (RAW+1)'(pop_ack) - (RAW+1)'(rsp_wr);
    rcnt_d = rcnt_q + (RAW+1)'(rsp_wr) - (RAW+1)'(rsp_rd);

    // Credit judged on next-cycle occupancy so a freed slot is usable at once
    credit_sum = {1'b0, out_d} + {1'b0, rcnt_d};
    credit     = credit_sum < (RAW+2)'(RSP_N);

    // Entry to present next cycle: the one behind the head when it is acked now
    nh_idx   = ack_fire ? qrd_q + QAW'(1) : qrd_q;
    nh_avail = (qcnt_q - (QAW+1)'(ack_fire)) != '0;
    nh       = req_mem_q[nh_idx];

    err_d = err_q | (req_acc & ~op_ok) | rsp_bad | (i_cmd_ack & (cmd_op_q == OP_NOP));
  end

  // Issue FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_op_q  <= OP_NOP;
      cmd_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_op_q  <= cmd_op_d;
      cmd_dat_q <= cmd_dat_d;
    end
  end

  // Issue FSM: next state (a held, un-acked command stays in DRIVE)
  always_comb begin
    state_d = IDLE;
    if ((state_q == DRIVE) && !ack_fire)         state_d = DRIVE;
    else if (!nh_avail)                          state_d = IDLE;
    else if ((nh.op == OP_POP) && !credit)       state_d = STALL;
    else                                         state_d = DRIVE;
  end

  // Issue FSM: outputs (registered via cmd_*_q)
  always_comb begin
    cmd_op_d  = OP_NOP;
    cmd_dat_d = '0;
    if (state_d == DRIVE) begin
      cmd_op_d  = nh.op;
      cmd_dat_d = nh.dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qwr_q  <= '0;
      qrd_q  <= '0;
      qcnt_q <= '0;
      rdy_q  <= 1'b0;
      rwr_q  <= '0;
      rrd_q  <= '0;
      rcnt_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (enq)      qwr_q <= qwr_q + QAW'(1);
      if (ack_fire) qrd_q <= qrd_q + QAW'(1);
      qcnt_q <= qcnt_d;
      rdy_q  <= qcnt_d != (QAW+1)'(REQ_N);
      if (rsp_wr)   rwr_q <= rwr_q + RAW'(1);
      if (rsp_rd)   rrd_q <= rrd_q + RAW'(1);
      rcnt_q <= rcnt_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq)    req_mem_q[qwr_q] <= '{op: i_req_opcode, dat: i_req_dat};
    if (!rst && rsp_wr) rbuf_q[rwr_q]    <= i_rsp_dat;
  end

  assign o_req_rdy    = rdy_q;
  assign o_cmd_opcode = cmd_op_q;
  assign o_cmd_dat    = cmd_dat_q;
  assign o_rsp_vld    = rcnt_q != '0;
  assign o_rsp_dat    = o_rsp_vld ? rbuf_q[rrd_q] : '0;
  assign o_busy       = (qcnt_q != '0) || (out_q != '0) || (rcnt_q != '0);
  assign o_err        = err_q;
endmodule

// File: tb/tb_stk_cmd_issuer.sv
// Directed bench for stk_cmd_issuer: issue, round trip, credit stall, full queue,
// error flags and mid-operation reset, each with hand-computed expectations.
module tb_stk_cmd_issuer;
  import stk_pkg::*;
  localparam int ENG   = 2;
  localparam int DAT_W = 128;
  localparam int EN    = cfg_pkg::ENGS_N;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_vld;
  opcode_t          req_op;
  logic [DAT_W-1:0] req_dat;
  logic             req_rdy;
  opcode_t          cmd_op;
  logic [DAT_W-1:0] cmd_dat;
  logic             cmd_ack, ack_man, auto_ack;
  logic [EN-1:0]    rsp_vld_in;
  logic [DAT_W-1:0] rsp_dat_in;
  logic             rsp_vld, rsp_rdy, busy, err;
  logic [DAT_W-1:0] rsp_dat;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Auto mode acks exactly when a real command is presented
  assign cmd_ack = auto_ack ? (cmd_op != OP_NOP) : ack_man;

  stk_cmd_issuer #(.ENG_ID(ENG), .REQ_N(4), .RSP_N(4), .DAT_W(DAT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req_vld(req_vld), .i_req_opcode(req_op), .i_req_dat(req_dat), .o_req_rdy(req_rdy),
    .o_cmd_opcode(cmd_op), .o_cmd_dat(cmd_dat), .i_cmd_ack(cmd_ack),
    .i_rsp_vld(rsp_vld_in), .i_rsp_dat(rsp_dat_in),
    .o_rsp_vld(rsp_vld), .o_rsp_dat(rsp_dat), .i_rsp_rdy(rsp_rdy),
    .o_busy(busy), .o_err(err)
  );

  task automatic chk(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic req(input opcode_t op, input logic [DAT_W-1:0] d);
    req_vld = 1'b1;
    req_op  = op;
    req_dat = d;
  endtask

  task automatic own_rsp(input logic [DAT_W-1:0] d);
    rsp_vld_in      = '0;
    rsp_vld_in[ENG] = 1'b1;
    rsp_dat_in      = d;
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_op = OP_NOP; req_dat = '0;
    ack_man = 1'b0; auto_ack = 1'b0; rsp_vld_in = '0; rsp_dat_in = '0; rsp_rdy = 1'b0;
    tick(); tick();
    chk("rst_cmd_op", cmd_op, OP_NOP);
    chk("rst_cmd_dat", cmd_dat, 0);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", req_rdy, 1);

    // Single PUSH held for three cycles until ack
    req(OP_PUSH, 'hA5);
    tick();
    req_vld = 1'b0;
    chk("push_latency_nop", cmd_op, OP_NOP);
    tick();
    chk("push_op", cmd_op, OP_PUSH);
    chk("push_dat", cmd_dat, 'hA5);
    tick();
    tick();
    chk("push_hold_op", cmd_op, OP_PUSH);
    chk("push_hold_dat", cmd_dat, 'hA5);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("push_done_op", cmd_op, OP_NOP);
    chk("push_done_busy", busy, 0);
    chk("push_no_rsp", rsp_vld, 0);

    // PUSH/POP round trip
    req(OP_PUSH, 'h11);
    tick();
    req(OP_POP, 'h0);
    tick();
    req_vld = 1'b0;
    chk("rt_push_op", cmd_op, OP_PUSH);
    chk("rt_push_dat", cmd_dat, 'h11);
    ack_man = 1'b1;
    tick();
    chk("rt_pop_op", cmd_op, OP_POP);
    tick();
    ack_man = 1'b0;
    chk("rt_idle_op", cmd_op, OP_NOP);
    chk("rt_busy_out", busy, 1);
    tick();
    own_rsp('h11);
    tick();
    rsp_vld_in = '0;
    chk("rt_rsp_vld", rsp_vld, 1);
    chk("rt_rsp_dat", rsp_dat, 'h11);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("rt_rsp_clear", rsp_vld, 0);
    chk("rt_busy_clear", busy, 0);
    chk("rt_err", err, 0);

    // Credit stall: five POPs against RSP_N=4
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req(OP_POP, 'h0);
      tick();
    end
    req_vld = 1'b0;
    tick();
    chk("stall_op", cmd_op, OP_NOP);
    chk("stall_busy", busy, 1);
    tick();
    chk("stall_hold_op", cmd_op, OP_NOP);
    own_rsp('hB1);
    tick();
    rsp_vld_in = '0;
    chk("stall_buffered_op", cmd_op, OP_NOP);
    chk("stall_rsp_vld", rsp_vld, 1);
    chk("stall_rsp_dat", rsp_dat, 'hB1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("stall_release_op", cmd_op, OP_POP);
    tick();
    chk("stall_issued_op", cmd_op, OP_NOP);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own_rsp('hC0 + DAT_W'(i));
      tick();
      chk("drain_order", rsp_dat, 'hC0 + DAT_W'(i));
    end
    rsp_vld_in = '0;
    tick();
    rsp_rdy = 1'b0;
    auto_ack = 1'b0;
    chk("drain_rsp_vld", rsp_vld, 0);
    chk("drain_busy", busy, 0);
    chk("drain_err", err, 0);

    // Queue full with ack held low
    for (int i = 0; i < 4; i++) begin
      req(OP_PUSH, 'hD0 + DAT_W'(i));
      tick();
    end
    chk("full_rdy", req_rdy, 0);
    req(OP_PUSH, 'hD4);
    tick();
    req_vld = 1'b0;
    chk("full_rdy_hold", req_rdy, 0);
    chk("full_head_dat", cmd_dat, 'hD0);
    ack_man = 1'b1;
    tick();
    chk("full_rdy_rise", req_rdy, 1);
    chk("full_next_dat", cmd_dat, 'hD1);
    tick();
    chk("full_d2", cmd_dat, 'hD2);
    tick();
    chk("full_d3", cmd_dat, 'hD3);
    tick();
    ack_man = 1'b0;
    chk("full_no_d4", cmd_op, OP_NOP);
    chk("full_busy", busy, 0);

    // Error flags
    rsp_vld_in = '0;
    rsp_vld_in[(ENG + 1) % EN] = 1'b1;
    tick();
    rsp_vld_in = '0;
    chk("other_eng_err", err, 0);
    chk("other_eng_rsp", rsp_vld, 0);
    own_rsp('hEE);
    tick();
    rsp_vld_in = '0;
    chk("stray_rsp_err", err, 1);
    chk("stray_rsp_drop", rsp_vld, 0);
    tick();
    chk("stray_rsp_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("nop_ack_err", err, 1);
    do_reset();
    req(OP_RSV, 'h5);
    tick();
    req_vld = 1'b0;
    chk("bad_op_err", err, 1);
    tick();
    chk("bad_op_dropped", busy, 0);
    chk("bad_op_nop", cmd_op, OP_NOP);

    // Reset mid-operation: 3 queued requests plus 1 outstanding POP
    do_reset();
    req(OP_POP, 'h0);
    tick();
    req(OP_PUSH, 'hF1);
    tick();
    ack_man = 1'b1;
    req(OP_PUSH, 'hF2);
    tick();
    ack_man = 1'b0;
    req(OP_PUSH, 'hF3);
    tick();
    req_vld = 1'b0;
    chk("mid_cmd_op", cmd_op, OP_PUSH);
    chk("mid_cmd_dat", cmd_dat, 'hF1);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_op", cmd_op, OP_NOP);
    chk("mid_rst_dat", cmd_dat, 0);
    chk("mid_rst_rdy", req_rdy, 0);
    chk("mid_rst_rsp", rsp_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    tick();
    chk("mid_rdy_back", req_rdy, 1);
    chk("mid_still_idle", cmd_op, OP_NOP);
    own_rsp('h77);
    tick();
    rsp_vld_in = '0;
    chk("mid_stray_err", err, 1);
    chk("mid_stray_rsp", rsp_vld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
